// File: rtl/bram_arbiter.sv
// -----------------------------------------------------------------------------
// bram_arbiter
//
// Shares one bram_wrapper between two clients. The write channel and the
// read-address channel each have an independent two-way round-robin arbiter.
// Every accepted read pushes its client id into a small tag FIFO, and each
// returning m_r_valid beat pops the head to route the data back to the client
// that issued the read.
//
// Handshake: a transfer happens on a rising edge where valid && ready. ready is
// combinational from the valids, addresses and arbiter state. A client keeps
// valid, address and data stable until it sees ready. The responses on
// cN_r_valid cannot be back-pressured.
//
// Ports
//   clk, reset                     clock, synchronous active-low reset
//   cN_w_valid/ready/address/data  client N write request (N = 0, 1)
//   cN_ar_valid/ready/address      client N read request
//   cN_r_valid/data                client N read response
//   m_w_valid/address/data         registered write to bram_wrapper
//   m_ar_valid/address             registered read address to bram_wrapper
//   m_r_valid/data                 read data from bram_wrapper
//   error                          sticky: a read beat arrived with no tag
// -----------------------------------------------------------------------------
module bram_arbiter #(
    parameter  int WIDTH           = 10,
    parameter  int DEPTH           = 10,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int AW              = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             c0_w_valid,
    output logic             c0_w_ready,
    input  logic [AW-1:0]    c0_w_address,
    input  logic [WIDTH-1:0] c0_w_data,
    input  logic             c0_ar_valid,
    output logic             c0_ar_ready,
    input  logic [AW-1:0]    c0_ar_address,
    output logic             c0_r_valid,
    output logic [WIDTH-1:0] c0_r_data,

    input  logic             c1_w_valid,
    output logic             c1_w_ready,
    input  logic [AW-1:0]    c1_w_address,
    input  logic [WIDTH-1:0] c1_w_data,
    input  logic             c1_ar_valid,
    output logic             c1_ar_ready,
    input  logic [AW-1:0]    c1_ar_address,
    output logic             c1_r_valid,
    output logic [WIDTH-1:0] c1_r_data,

    output logic             m_w_valid,
    output logic [AW-1:0]    m_w_address,
    output logic [WIDTH-1:0] m_w_data,
    output logic             m_ar_valid,
    output logic [AW-1:0]    m_ar_address,
    input  logic             m_r_valid,
    input  logic [WIDTH-1:0] m_r_data,

    output logic             error
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(MAX_OUTSTANDING);

    // Arbiter pointers: the client that wins when both request.
    logic                       r_wp;
    logic                       r_rp;

    // Tag FIFO: one bit per outstanding read, holding the issuing client id.
    logic [MAX_OUTSTANDING-1:0] r_tag;
    logic [PW-1:0]              r_wr_ptr;
    logic [PW-1:0]              r_rd_ptr;
    logic [CW-1:0]              r_count;

    logic                       r_m_w_valid;
    logic [AW-1:0]              r_m_w_address;
    logic [WIDTH-1:0]           r_m_w_data;
    logic                       r_m_ar_valid;
    logic [AW-1:0]              r_m_ar_address;
    logic                       r_error;

    logic                       w_wgnt0;
    logic                       w_wgnt1;
    logic                       w_wgnt_any;
    logic [AW-1:0]              w_waddr;
    logic                       w_rcand0;
    logic                       w_rcand1;
    logic [AW-1:0]              w_raddr;
    logic                       w_full;
    logic                       w_collision;
    logic                       w_rgnt0;
    logic                       w_rgnt1;
    logic                       w_rgnt_any;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_head;

    // Write arbitration; everything is held off while reset is asserted.
    assign w_wgnt0    = reset && c0_w_valid && (!c1_w_valid || (r_wp == 1'b0));
    assign w_wgnt1    = reset && c1_w_valid && (!c0_w_valid || (r_wp == 1'b1));
    assign w_wgnt_any = w_wgnt0 || w_wgnt1;
    assign w_waddr    = w_wgnt1 ? c1_w_address : c0_w_address;

    // Read candidate before gating, using the same round-robin rule.
    assign w_rcand0 = c0_ar_valid && (!c1_ar_valid || (r_rp == 1'b0));
    assign w_rcand1 = c1_ar_valid && (!c0_ar_valid || (r_rp == 1'b1));
    assign w_raddr  = w_rcand1 ? c1_ar_address : c0_ar_address;

    // Full ignores a same-cycle pop so ready never depends on m_r_valid.
    assign w_full = (r_count == FULL_COUNT);

    // A read that hits the address being written this cycle waits one cycle,
    // so it is issued after the write and returns the new data. rp stays put.
    assign w_collision = w_wgnt_any && (w_rcand0 || w_rcand1) && (w_waddr == w_raddr);

    assign w_rgnt0    = reset && w_rcand0 && !w_full && !w_collision;
    assign w_rgnt1    = reset && w_rcand1 && !w_full && !w_collision;
    assign w_rgnt_any = w_rgnt0 || w_rgnt1;

    assign w_push = w_rgnt_any;
    assign w_pop  = reset && m_r_valid && (r_count != '0);
    assign w_head = r_tag[r_rd_ptr];

    assign c0_w_ready  = w_wgnt0;
    assign c1_w_ready  = w_wgnt1;
    assign c0_ar_ready = w_rgnt0;
    assign c1_ar_ready = w_rgnt1;

    // Response routing: data is broadcast, valid goes only to the tag owner.
    // A beat with an empty FIFO (w_pop low) reaches neither client.
    assign c0_r_valid = w_pop && (w_head == 1'b0);
    assign c1_r_valid = w_pop && (w_head == 1'b1);
    assign c0_r_data  = m_r_data;
    assign c1_r_data  = m_r_data;

    assign m_w_valid    = r_m_w_valid;
    assign m_w_address  = r_m_w_address;
    assign m_w_data     = r_m_w_data;
    assign m_ar_valid   = r_m_ar_valid;
    assign m_ar_address = r_m_ar_address;
    assign error        = r_error;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wp           <= 1'b0;
            r_rp           <= 1'b0;
            r_tag          <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_m_w_valid    <= 1'b0;
            r_m_w_address  <= '0;
            r_m_w_data     <= '0;
            r_m_ar_valid   <= 1'b0;
            r_m_ar_address <= '0;
            r_error        <= 1'b0;
        end else begin
            r_m_w_valid  <= w_wgnt_any;
            r_m_ar_valid <= w_rgnt_any;

            // Address/data only update on a grant so they hold when idle.
            if (w_wgnt_any) begin
                r_m_w_address <= w_waddr;
                r_m_w_data    <= w_wgnt1 ? c1_w_data : c0_w_data;
                // Granting client 0 hands priority to client 1, and vice versa.
                r_wp          <= w_wgnt0;
            end

            if (w_rgnt_any) begin
                r_m_ar_address <= w_raddr;
                r_rp           <= w_rgnt0;
            end

            if (w_push) begin
                r_tag[r_wr_ptr] <= w_rgnt1;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (m_r_valid && (r_count == '0)) begin
                r_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_arbiter
//
// Directed bench for bram_arbiter. A behavioural one-cycle BRAM model answers
// m_ar_valid when bram_en is set; otherwise the bench injects m_r_valid beats
// directly (stalled BRAM, stray returns). Inputs change on the falling edge,
// combinational readies are sampled 1 ns later, registered outputs are sampled
// on the falling edge that follows the rising edge that produced them.
// -----------------------------------------------------------------------------
module tb_bram_arbiter;

    localparam int WIDTH = 10;
    localparam int DEPTH = 10;
    localparam int MO    = 4;
    localparam int AW    = $clog2(DEPTH);

    logic             clk;
    logic             reset;

    logic             c0_w_valid;
    logic             c0_w_ready;
    logic [AW-1:0]    c0_w_address;
    logic [WIDTH-1:0] c0_w_data;
    logic             c0_ar_valid;
    logic             c0_ar_ready;
    logic [AW-1:0]    c0_ar_address;
    logic             c0_r_valid;
    logic [WIDTH-1:0] c0_r_data;

    logic             c1_w_valid;
    logic             c1_w_ready;
    logic [AW-1:0]    c1_w_address;
    logic [WIDTH-1:0] c1_w_data;
    logic             c1_ar_valid;
    logic             c1_ar_ready;
    logic [AW-1:0]    c1_ar_address;
    logic             c1_r_valid;
    logic [WIDTH-1:0] c1_r_data;

    logic             m_w_valid;
    logic [AW-1:0]    m_w_address;
    logic [WIDTH-1:0] m_w_data;
    logic             m_ar_valid;
    logic [AW-1:0]    m_ar_address;
    logic             m_r_valid;
    logic [WIDTH-1:0] m_r_data;
    logic             error;

    int tests_run;
    int fails;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- BRAM model ----------------
    logic             bram_en;
    logic             bram_rv;
    logic [WIDTH-1:0] bram_rd;
    logic             inj_rv;
    logic [WIDTH-1:0] inj_rd;
    logic             pre_we;
    logic [AW-1:0]    pre_addr;
    logic [WIDTH-1:0] pre_data;
    logic [WIDTH-1:0] mem [0:15];

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (m_w_valid) mem[m_w_address] <= m_w_data;
        bram_rv <= m_ar_valid;
        bram_rd <= mem[m_ar_address];
    end

    assign m_r_valid = bram_en ? bram_rv : inj_rv;
    assign m_r_data  = bram_en ? bram_rd : inj_rd;

    bram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_OUTSTANDING(MO)) dut (
        .clk           (clk),
        .reset         (reset),
        .c0_w_valid    (c0_w_valid),
        .c0_w_ready    (c0_w_ready),
        .c0_w_address  (c0_w_address),
        .c0_w_data     (c0_w_data),
        .c0_ar_valid   (c0_ar_valid),
        .c0_ar_ready   (c0_ar_ready),
        .c0_ar_address (c0_ar_address),
        .c0_r_valid    (c0_r_valid),
        .c0_r_data     (c0_r_data),
        .c1_w_valid    (c1_w_valid),
        .c1_w_ready    (c1_w_ready),
        .c1_w_address  (c1_w_address),
        .c1_w_data     (c1_w_data),
        .c1_ar_valid   (c1_ar_valid),
        .c1_ar_ready   (c1_ar_ready),
        .c1_ar_address (c1_ar_address),
        .c1_r_valid    (c1_r_valid),
        .c1_r_data     (c1_r_data),
        .m_w_valid     (m_w_valid),
        .m_w_address   (m_w_address),
        .m_w_data      (m_w_data),
        .m_ar_valid    (m_ar_valid),
        .m_ar_address  (m_ar_address),
        .m_r_valid     (m_r_valid),
        .m_r_data      (m_r_data),
        .error         (error)
    );

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic drop_all;
        c0_w_valid  = 1'b0;
        c1_w_valid  = 1'b0;
        c0_ar_valid = 1'b0;
        c1_ar_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        @(negedge clk);
        reset         = 1'b0;
        c0_w_valid    = 1'b1; c0_w_address  = 4'd1; c0_w_data = 10'h011;
        c1_w_valid    = 1'b1; c1_w_address  = 4'd2; c1_w_data = 10'h022;
        c0_ar_valid   = 1'b1; c0_ar_address = 4'd7;
        c1_ar_valid   = 1'b1; c1_ar_address = 4'd8;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if ({c0_w_ready, c1_w_ready, c0_ar_ready, c1_ar_ready} !== 4'b0000) begin
                fails++;
                $display("FAIL reset_readies cyc%0d: got %b exp 0000", k,
                         {c0_w_ready, c1_w_ready, c0_ar_ready, c1_ar_ready});
            end
            tests_run++;
            if ({m_w_valid, m_ar_valid, error} !== 3'b000) begin
                fails++;
                $display("FAIL reset_outputs cyc%0d: got %b exp 000", k, {m_w_valid, m_ar_valid, error});
            end
        end
        tests_run++;
        if ({m_w_address, m_w_data, m_ar_address} !== '0) begin
            fails++;
            $display("FAIL reset_m_fields: got %h/%h/%h exp 0/0/0", m_w_address, m_w_data, m_ar_address);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({c0_w_ready, c1_w_ready, c0_ar_ready, c1_ar_ready} !== 4'b1010) begin
            fails++;
            $display("FAIL release_readies: got %b exp 1010",
                     {c0_w_ready, c1_w_ready, c0_ar_ready, c1_ar_ready});
        end
        drop_all();
    endtask

    task automatic test_contention;
        logic [AW-1:0] exp_addr;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                c0_w_valid = 1'b1; c0_w_address = 4'd1; c0_w_data = 10'h011;
                c1_w_valid = 1'b1; c1_w_address = 4'd2; c1_w_data = 10'h022;
            end else begin
                exp_addr = ((k - 1) % 2 == 0) ? 4'd1 : 4'd2;
                tests_run++;
                if (m_w_valid !== 1'b1 || m_w_address !== exp_addr) begin
                    fails++;
                    $display("FAIL contention_issue k%0d: got v=%b a=%0d exp v=1 a=%0d",
                             k, m_w_valid, m_w_address, exp_addr);
                end
            end
            #1;
            tests_run++;
            if ({c0_w_ready, c1_w_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                fails++;
                $display("FAIL contention_grant k%0d: got %b exp %b", k, {c0_w_ready, c1_w_ready},
                         (k % 2 == 0) ? 2'b10 : 2'b01);
            end
        end
        @(negedge clk);
        drop_all();
        tests_run++;
        if (m_w_valid !== 1'b1 || m_w_address !== 4'd2 || m_w_data !== 10'h022) begin
            fails++;
            $display("FAIL contention_last: got v=%b a=%0d d=%h exp v=1 a=2 d=022",
                     m_w_valid, m_w_address, m_w_data);
        end
        @(negedge clk);
        tests_run++;
        if (m_w_valid !== 1'b0 || m_w_address !== 4'd2) begin
            fails++;
            $display("FAIL contention_idle_hold: got v=%b a=%0d exp v=0 a=2", m_w_valid, m_w_address);
        end
    endtask

    task automatic test_read_routing;
        bram_en = 1'b1;
        preload(4'd3, 10'h155);
        preload(4'd4, 10'h0AA);
        @(negedge clk);
        c0_ar_valid = 1'b1; c0_ar_address = 4'd3;
        #1;
        tests_run++;
        if ({c0_ar_ready, c1_ar_ready} !== 2'b10) begin
            fails++;
            $display("FAIL route_grant0: got %b exp 10", {c0_ar_ready, c1_ar_ready});
        end
        @(negedge clk);
        c0_ar_valid = 1'b0;
        c1_ar_valid = 1'b1; c1_ar_address = 4'd4;
        #1;
        tests_run++;
        if ({c0_ar_ready, c1_ar_ready} !== 2'b01) begin
            fails++;
            $display("FAIL route_grant1: got %b exp 01", {c0_ar_ready, c1_ar_ready});
        end
        tests_run++;
        if (m_ar_valid !== 1'b1 || m_ar_address !== 4'd3) begin
            fails++;
            $display("FAIL route_issue0: got v=%b a=%0d exp v=1 a=3", m_ar_valid, m_ar_address);
        end
        @(negedge clk);
        c1_ar_valid = 1'b0;
        tests_run++;
        if (m_ar_valid !== 1'b1 || m_ar_address !== 4'd4) begin
            fails++;
            $display("FAIL route_issue1: got v=%b a=%0d exp v=1 a=4", m_ar_valid, m_ar_address);
        end
        tests_run++;
        if ({c0_r_valid, c1_r_valid} !== 2'b10 || c0_r_data !== 10'h155) begin
            fails++;
            $display("FAIL route_ret0: got v=%b d=%h exp v=10 d=155", {c0_r_valid, c1_r_valid}, c0_r_data);
        end
        @(negedge clk);
        tests_run++;
        if ({c0_r_valid, c1_r_valid} !== 2'b01 || c1_r_data !== 10'h0AA) begin
            fails++;
            $display("FAIL route_ret1: got v=%b d=%h exp v=01 d=0aa", {c0_r_valid, c1_r_valid}, c1_r_data);
        end
        @(negedge clk);
        tests_run++;
        if ({c0_r_valid, c1_r_valid} !== 2'b00) begin
            fails++;
            $display("FAIL route_quiet: got %b exp 00", {c0_r_valid, c1_r_valid});
        end
    endtask

    task automatic test_collision;
        preload(4'd5, 10'h001);
        @(negedge clk);
        c0_w_valid  = 1'b1; c0_w_address  = 4'd5; c0_w_data = 10'h3FF;
        c1_ar_valid = 1'b1; c1_ar_address = 4'd5;
        #1;
        tests_run++;
        if ({c0_w_ready, c0_ar_ready, c1_ar_ready} !== 3'b100) begin
            fails++;
            $display("FAIL collision_block: got %b exp 100", {c0_w_ready, c0_ar_ready, c1_ar_ready});
        end
        @(negedge clk);
        c0_w_valid = 1'b0;
        #1;
        tests_run++;
        if (c1_ar_ready !== 1'b1) begin
            fails++;
            $display("FAIL collision_retry: got %b exp 1", c1_ar_ready);
        end
        tests_run++;
        if (m_w_valid !== 1'b1 || m_w_address !== 4'd5 || m_w_data !== 10'h3FF || m_ar_valid !== 1'b0) begin
            fails++;
            $display("FAIL collision_write_first: got wv=%b a=%0d d=%h arv=%b exp 1/5/3ff/0",
                     m_w_valid, m_w_address, m_w_data, m_ar_valid);
        end
        @(negedge clk);
        c1_ar_valid = 1'b0;
        tests_run++;
        if (m_ar_valid !== 1'b1 || m_ar_address !== 4'd5) begin
            fails++;
            $display("FAIL collision_read_issue: got v=%b a=%0d exp v=1 a=5", m_ar_valid, m_ar_address);
        end
        @(negedge clk);
        tests_run++;
        if ({c0_r_valid, c1_r_valid} !== 2'b01 || c1_r_data !== 10'h3FF) begin
            fails++;
            $display("FAIL collision_data: got v=%b d=%h exp v=01 d=3ff", {c0_r_valid, c1_r_valid}, c1_r_data);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        c0_w_valid  = 1'b1; c0_w_address  = 4'd9; c0_w_data = 10'h2A5;
        c0_ar_valid = 1'b1; c0_ar_address = 4'd5;
        #1;
        tests_run++;
        if ({c0_w_ready, c0_ar_ready} !== 2'b11) begin
            fails++;
            $display("FAIL b2b_same_client0: got %b exp 11", {c0_w_ready, c0_ar_ready});
        end
        @(negedge clk);
        c0_w_valid  = 1'b0; c0_ar_valid = 1'b0;
        c1_w_valid  = 1'b1; c1_w_address  = 4'd6; c1_w_data = 10'h0F0;
        c1_ar_valid = 1'b1; c1_ar_address = 4'd9;
        #1;
        tests_run++;
        if ({c1_w_ready, c1_ar_ready} !== 2'b11) begin
            fails++;
            $display("FAIL b2b_same_client1: got %b exp 11", {c1_w_ready, c1_ar_ready});
        end
        tests_run++;
        if (m_w_valid !== 1'b1 || m_w_address !== 4'd9 || m_ar_valid !== 1'b1 || m_ar_address !== 4'd5) begin
            fails++;
            $display("FAIL b2b_issue0: got w=%b/%0d ar=%b/%0d exp 1/9 1/5",
                     m_w_valid, m_w_address, m_ar_valid, m_ar_address);
        end
        @(negedge clk);
        drop_all();
        tests_run++;
        if (m_w_address !== 4'd6 || m_w_data !== 10'h0F0 || m_ar_address !== 4'd9) begin
            fails++;
            $display("FAIL b2b_issue1: got wa=%0d wd=%h ara=%0d exp 6/0f0/9", m_w_address, m_w_data, m_ar_address);
        end
        tests_run++;
        if (c0_r_valid !== 1'b1 || c0_r_data !== 10'h3FF) begin
            fails++;
            $display("FAIL b2b_ret0: got v=%b d=%h exp v=1 d=3ff", c0_r_valid, c0_r_data);
        end
        @(negedge clk);
        tests_run++;
        if (c1_r_valid !== 1'b1 || c1_r_data !== 10'h2A5) begin
            fails++;
            $display("FAIL b2b_ret1: got v=%b d=%h exp v=1 d=2a5", c1_r_valid, c1_r_data);
        end
        repeat (2) @(negedge clk);
        bram_en = 1'b0;
        inj_rv  = 1'b0;
    endtask

    task automatic test_full;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 0) begin
                c0_ar_valid = 1'b1; c0_ar_address = 4'd6;
            end
            #1;
            tests_run++;
            if (c0_ar_ready !== ((k < MO) ? 1'b1 : 1'b0)) begin
                fails++;
                $display("FAIL full_ready k%0d: got %b exp %b", k, c0_ar_ready, (k < MO) ? 1'b1 : 1'b0);
            end
        end
        @(negedge clk);
        inj_rv = 1'b1; inj_rd = 10'h077;
        #1;
        tests_run++;
        if (c0_ar_ready !== 1'b0 || c0_r_valid !== 1'b1 || c0_r_data !== 10'h077) begin
            fails++;
            $display("FAIL full_pop_cycle: got rdy=%b rv=%b d=%h exp 0/1/077", c0_ar_ready, c0_r_valid, c0_r_data);
        end
        @(negedge clk);
        inj_rv = 1'b0;
        #1;
        tests_run++;
        if (c0_ar_ready !== 1'b1) begin
            fails++;
            $display("FAIL full_reopen: got %b exp 1", c0_ar_ready);
        end
        c0_ar_valid = 1'b0;
        // Three tags remain; drain them.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            inj_rv = 1'b1; inj_rd = WIDTH'(k);
            #1;
            tests_run++;
            if ({c0_r_valid, c1_r_valid} !== 2'b10) begin
                fails++;
                $display("FAIL full_drain k%0d: got %b exp 10", k, {c0_r_valid, c1_r_valid});
            end
        end
        @(negedge clk);
        inj_rv = 1'b0;
        tests_run++;
        if (error !== 1'b0) begin
            fails++;
            $display("FAIL full_no_error: got %b exp 0", error);
        end
    endtask

    task automatic test_error;
        @(negedge clk);
        inj_rv = 1'b1; inj_rd = 10'h155;
        #1;
        tests_run++;
        if ({c0_r_valid, c1_r_valid, error} !== 3'b000) begin
            fails++;
            $display("FAIL error_stray_route: got %b exp 000", {c0_r_valid, c1_r_valid, error});
        end
        @(negedge clk);
        inj_rv = 1'b0;
        tests_run++;
        if (error !== 1'b1) begin
            fails++;
            $display("FAIL error_set: got %b exp 1", error);
        end
        @(negedge clk);
        tests_run++;
        if (error !== 1'b1) begin
            fails++;
            $display("FAIL error_sticky: got %b exp 1", error);
        end
    endtask

    task automatic test_reset_midflight;
        @(negedge clk);
        c0_ar_valid = 1'b1; c0_ar_address = 4'd1;
        #1;
        tests_run++;
        if (c0_ar_ready !== 1'b1) begin
            fails++;
            $display("FAIL midflight_rd0: got %b exp 1", c0_ar_ready);
        end
        @(negedge clk);
        c0_ar_valid = 1'b0;
        c1_ar_valid = 1'b1; c1_ar_address = 4'd2;
        #1;
        tests_run++;
        if (c1_ar_ready !== 1'b1) begin
            fails++;
            $display("FAIL midflight_rd1: got %b exp 1", c1_ar_ready);
        end
        @(negedge clk);
        c1_ar_valid = 1'b0;
        reset  = 1'b0;
        inj_rv = 1'b1; inj_rd = 10'h0AA;
        #1;
        tests_run++;
        if ({c0_r_valid, c1_r_valid} !== 2'b00) begin
            fails++;
            $display("FAIL midflight_ignore_in_reset: got %b exp 00", {c0_r_valid, c1_r_valid});
        end
        @(negedge clk);
        reset  = 1'b1;
        inj_rv = 1'b0;
        tests_run++;
        if (error !== 1'b0 || m_ar_valid !== 1'b0) begin
            fails++;
            $display("FAIL midflight_cleared: got err=%b arv=%b exp 0/0", error, m_ar_valid);
        end
        @(negedge clk);
        inj_rv = 1'b1;
        #1;
        tests_run++;
        if ({c0_r_valid, c1_r_valid} !== 2'b00) begin
            fails++;
            $display("FAIL midflight_tags_dropped: got %b exp 00", {c0_r_valid, c1_r_valid});
        end
        @(negedge clk);
        inj_rv = 1'b0;
        tests_run++;
        if (error !== 1'b1) begin
            fails++;
            $display("FAIL midflight_stray_error: got %b exp 1", error);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        tests_run     = 0;
        fails         = 0;
        reset         = 1'b0;
        bram_en       = 1'b0;
        inj_rv        = 1'b0;
        inj_rd        = '0;
        pre_we        = 1'b0;
        pre_addr      = '0;
        pre_data      = '0;
        c0_w_address  = '0; c0_w_data = '0; c0_ar_address = '0;
        c1_w_address  = '0; c1_w_data = '0; c1_ar_address = '0;
        drop_all();

        test_reset();
        test_contention();
        test_read_routing();
        test_collision();
        test_back_to_back();
        test_full();
        test_error();
        test_reset_midflight();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-client arbiter that shares a single `bram_wrapper` instance between two requesters. It provides independent round-robin arbitration on the write channel and the read-address channel. Each read is tagged with its owner so that returning `r_valid`/`r_data` beats are routed back to the client that issued it. The block sits directly in front of `bram_wrapper`, and its BRAM-side ports connect one-to-one to that block's `w_*`, `ar_*` and `r_*` ports.

## Interface
- `WIDTH`, 10: data width, matches `bram_wrapper`
- `DEPTH`, 10: words in BRAM; address width `AW = $clog2(DEPTH)`
- `MAX_OUTSTANDING`, 4: reads in flight (tag FIFO depth), power of two, ≥2
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-low
- `cN_w_valid` in 1 (N=0,1): client write request
- `cN_w_ready` out 1: write accepted this cycle
- `cN_w_address` in AW: write address
- `cN_w_data` in WIDTH: write data
- `cN_ar_valid` in 1: client read request
- `cN_ar_ready` out 1: read accepted this cycle
- `cN_ar_address` in AW: read address
- `cN_r_valid` out 1: read data for client N
- `cN_r_data` out WIDTH: read data
- `m_w_valid`, `m_w_address`, `m_w_data` out 1/AW/WIDTH: to BRAM write port, registered
- `m_ar_valid`, `m_ar_address` out 1/AW: to BRAM read-address port, registered
- `m_r_valid`, `m_r_data` in 1/WIDTH: from BRAM read port
- `error` out 1: sticky; set when `m_r_valid` arrives with the tag FIFO empty

## Operation
- **Handshake:** a transfer occurs when `valid && ready`. `ready` is combinational from the valids and the arbiter state. A client must hold valid, address and data stable until ready.
- **Write arbitration:** priority pointer `wp`. If only one client is valid, it is granted. If both are valid, client `wp` is granted. After any grant, `wp` moves to the other client.
- **Read arbitration:** identical scheme with its own pointer `rp`, subject to two gating rules:
  - **Full:** if the tag FIFO count equals `MAX_OUTSTANDING`, both `cN_ar_ready` are low. This applies even if a pop happens in the same cycle.
  - **Collision:** if the granted write and the candidate read target the same address in the same cycle, the read is not granted. Both `ar_ready` are low and `rp` does not advance, so the write wins and the read retries next cycle.
- **Issue:**
  - A granted write drives `m_w_valid/address/data` on the next cycle.
  - A granted read drives `m_ar_valid/address` on the next cycle and pushes the client id into the tag FIFO in the grant cycle.
  - When there is no grant, `m_*_valid` is 0 the next cycle. Address and data hold their last values.
- **Return:** on `m_r_valid`, the FIFO head `h` selects the client:
  - `ch_r_valid = 1` and `ch_r_data = m_r_data`, combinational.
  - The head is popped.
  - The other client's `r_valid` is 0.
  - `cN_r_data` mirrors `m_r_data` for both clients.
  - Clients cannot backpressure responses.
- **FIFO:**
  - Count width is `$clog2(MAX_OUTSTANDING)+1`.
  - A push and a pop in the same cycle leave the count unchanged.
  - Read/write pointers wrap modulo `MAX_OUTSTANDING`.
- **Error:** `m_r_valid` with count 0 sets `error`, routes the beat to no client, and leaves the FIFO unchanged. `error` clears only on reset.

## Timing
- **Reset** (`reset==0` at a clock edge):
  - All `m_*` outputs go to 0.
  - `wp = rp = 0`, FIFO count 0, `error = 0`.
  - `cN_w_ready`/`cN_ar_ready` are forced to 0 while reset is low.
  - Reset mid-operation discards all in-flight tags. `m_r_valid` is ignored while reset is low.
- **Latency:**
  - `valid&&ready` to `m_*_valid`: 1 cycle.
  - Client read data follows `m_r_valid` with 0 added cycles, i.e. 1 + BRAM read latency.
- **Throughput:** one write and one read per cycle, from different clients or from the same client.
- **Simultaneous events:**
  - Write to X and read from X from any clients in the same cycle: the write issues first and the read issues one cycle later, so the read returns the new data.
  - Full, with a return in the grant cycle: no grant that cycle; a grant is possible next cycle.
- **Ordering:** responses return in issue order, and the FIFO relies on `bram_wrapper` preserving order.

## Test plan
- **Reset:** hold `reset=0` 3 cycles with all valids high → all readies 0, all `m_*_valid` 0, `error=0`. First cycle after release: `c0_w_ready=1`, `c1_w_ready=0`.
- **Contention:** both clients hold `w_valid` for 4 cycles, addresses 1 and 2 → grants c0,c1,c0,c1. `m_w_address` sequence 1,2,1,2, each one cycle after its grant.
- **Read routing:**
  - c0 reads addr 3 (holding 0x155), then c1 reads addr 4 (holding 0x0AA) in the next cycle.
  - Required: `c0_r_valid` with 0x155, then `c1_r_valid` with 0x0AA, never crossed.
- **Collision:** c0 writes 0x3FF to addr 5 while c1 reads addr 5 → `c1_ar_ready=0` that cycle and 1 the next. `c1_r_data=0x3FF`.
- **Full:**
  - Stub BRAM never returns; c0 issues reads back-to-back.
  - Exactly 4 `ar_ready` pulses, then `ar_ready` stays 0.
  - One `m_r_valid` → `ar_ready` returns the following cycle.
- **Error and reset mid-flight:**
  - Inject `m_r_valid` with no outstanding reads → `error=1`, no `cN_r_valid`.
  - Pulse reset with 2 reads in flight → `error=0`, count 0, later stray returns set `error`.
